scrambler_gen: RTL and testbench
================================

SCRAMBLER_GEN -- requirements
Module: scrambler_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 58: data word width, legal range 1..ORDER.
REQ-002 The block SHALL have parameter ORDER, default 58: recursion order, equal to the history length in bits.
REQ-003 The block SHALL have parameter TAP, default 39: inner tap, legal range 1..ORDER-1.
REQ-004 The block SHALL have parameter INIT_SEED, default 58'h112abaa1231ba11: history value loaded on reset or reseed, ORDER bits wide.
REQ-005 The block SHALL have parameter DESCRAMBLE, default 0: 0 = scrambler, 1 = self-synchronising descrambler.
REQ-006 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port data_in, input, WIDTH bits: input word, bit 0 earliest in the serial stream.
REQ-009 The block SHALL have port in_valid, input, 1 bit: data_in is qualified.
REQ-010 The block SHALL have port enable, input, 1 bit: when low, stall with all registers held.
REQ-011 The block SHALL have port bypass, input, 1 bit: output the input unmodified.
REQ-012 The block SHALL have port reseed, input, 1 bit: synchronous single-cycle request to reload INIT_SEED.
REQ-013 The block SHALL have port data_out, output, WIDTH bits: registered result.
REQ-014 The block SHALL have port out_valid, output, 1 bit: data_out is qualified.
REQ-015 The block SHALL have port locked, output, 1 bit: the history register is fully populated with line data.

Function
REQ-016 The block SHALL use stream recursion S(n) = D(n) xnor S(n-TAP) xnor S(n-ORDER), which is equivalent to D xor S(n-TAP) xor S(n-ORDER).
REQ-017 The history register SHALL be ORDER bits: bit ORDER-1 = most recent stream bit, bit 0 = oldest.
REQ-018 In scramble mode, the history SHALL be fed by the produced S bits; in descramble mode, it SHALL be fed by the received data_in bits, and data_out SHALL equal data_in xor S(n-TAP) xor S(n-ORDER).
REQ-019 Within one word, bit k SHALL use taps that resolve to earlier bits of the same word when k >= TAP (or k >= ORDER), and to history otherwise, computed combinationally in one cycle.
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge t appears on data_out with out_valid=1 after edge t.
REQ-021 A word SHALL be accepted only when enable=1 and in_valid=1.
REQ-022 When enable=1 and in_valid=0, out_valid SHALL go to 0, and data_out and history SHALL be held.
REQ-023 When enable=0, data_out, out_valid, history, and the lock counter SHALL all be held.
REQ-024 When bypass=1 and a word is accepted, data_out SHALL equal data_in and the history SHALL NOT be updated.
REQ-025 A lock counter SHALL count accepted non-bypass words, saturating at LOCK_WORDS = ceil(ORDER/WIDTH).
REQ-026 locked SHALL equal 1 when the count equals LOCK_WORDS.
REQ-027 reseed=1 with enable=1 SHALL load INIT_SEED into the history and clear the lock counter, taking priority over an accepted word in the same cycle.
REQ-028 When reseed and an accepted word occur in the same cycle, the word SHALL be processed against the old history, output with out_valid=1, and its history update discarded.
REQ-029 reseed with enable=0 SHALL be ignored.
REQ-030 bypass SHALL be sampled per word, and toggling bypass mid-stream SHALL NOT disturb the history.
REQ-031 WIDTH=ORDER=58, TAP=39 SHALL be bit-exact with the existing 58-bit lpGBT scrambler for identical seed and data.

Reset
REQ-032 While reset_n=0, asynchronously: data_out SHALL be 0, out_valid 0, history INIT_SEED, lock counter 0, and locked 0.
REQ-033 Reset deassertion mid-stream SHALL discard any in-flight word, with no partial output.
REQ-034 The first word SHALL be accepted at the first rising edge of clock after reset_n goes high.

Verification
REQ-035 A bench SHALL cover: INIT_SEED=0, WIDTH=58, data_in=58'h1 single word -> data_out=58'h80_0000_0001 one cycle later, out_valid=1.
REQ-036 A bench SHALL cover: INIT_SEED=0, data_in=0 for 10 words -> data_out=0 on every word, and locked=1 from the 2nd output onward (LOCK_WORDS=1).
REQ-037 A bench SHALL cover: scrambler to descrambler loopback with different seeds, WIDTH=16, 1000 random words -> descrambler output equals the original from word ceil(58/16)+1=5 onward, and locked rises after the 4th word.
REQ-038 A bench SHALL cover: enable=0 for 5 cycles mid-stream -> data_out and out_valid frozen, and the stream after resume is identical to the same stream run without the stall.
REQ-039 A bench SHALL cover: bypass=1 for 3 words mid-stream -> those outputs equal the inputs, and subsequent scrambled words are identical to a run with those 3 words removed.
REQ-040 A bench SHALL cover: reseed coincident with an accepted word, and reset_n pulsed low mid-stream -> outputs match REQ-027, REQ-028 and REQ-032, with data_out=0 and locked=0 immediately while reset_n=0.

Source files
------------

// File: rtl/scrambler_gen.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_gen
// Brief    : Word-parallel self-synchronising (de)scrambler, S = D ^ S[n-TAP] ^ S[n-ORDER].
// Revision : 1.0
// ============================================================================
module scrambler_gen #(
  parameter int               WIDTH      = 58,
  parameter int               ORDER      = 58,
  parameter int               TAP        = 39,
  parameter logic [ORDER-1:0] INIT_SEED  = 58'h112abaa1231ba11,
  parameter int               DESCRAMBLE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  input  logic             enable,
  input  logic             bypass,
  input  logic             reseed,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             locked
);

  localparam int               LOCK_WORDS = (ORDER + WIDTH - 1) / WIDTH;
  localparam int               CNT_W      = $clog2(LOCK_WORDS + 1);
  localparam logic [CNT_W-1:0] LOCK_CNT   = CNT_W'(LOCK_WORDS);

  logic [ORDER-1:0] hist_q, hist_d, hist_nxt;
  logic [WIDTH-1:0] dout_q, dout_d, res;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = enable & in_valid;

  // ext holds history below the current word's stream bits, so both taps are
  // plain indices: S(n-TAP) = ext[ORDER+k-TAP], S(n-ORDER) = ext[k].
  generate
    if (DESCRAMBLE != 0) begin : g_descramble
      always_comb begin
        logic [ORDER+WIDTH-1:0] ext;
        ext = {data_in, hist_q};
        res = '0;
        for (int k = 0; k < WIDTH; k++) begin
          res[k] = data_in[k] ^ ext[ORDER+k-TAP] ^ ext[k];
        end
        hist_nxt = ext[ORDER+WIDTH-1:WIDTH];
      end
    end else begin : g_scramble
      always_comb begin
        logic [ORDER+WIDTH-1:0] ext;
        ext = {{WIDTH{1'b0}}, hist_q};
        res = '0;
        for (int k = 0; k < WIDTH; k++) begin
          res[k]       = data_in[k] ^ ext[ORDER+k-TAP] ^ ext[k];
          ext[ORDER+k] = res[k];
        end
        hist_nxt = ext[ORDER+WIDTH-1:WIDTH];
      end
    end
  endgenerate

  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (enable) begin
      vld_d = in_valid;
      if (accept) begin
        dout_d = bypass ? data_in : res;
        if (!bypass) begin
          hist_d = hist_nxt;
          if (cnt_q != LOCK_CNT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Reseed wins over the word's history update; the word itself still goes out.
      if (reseed) begin
        hist_d = INIT_SEED;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      hist_q <= INIT_SEED;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = vld_q;
  assign locked    = (cnt_q == LOCK_CNT);

endmodule
`default_nettype wire

// File: tb/tb_scrambler_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_scrambler_gen
// Brief    : Directed bench: 58-bit scrambler against a bit-serial model, 16-bit loopback.
// Revision : 1.0
// ============================================================================
module tb_scrambler_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic [57:0] a_din, a_dout;
  logic        a_iv, a_en, a_byp, a_rs, a_ov, a_lk;

  scrambler_gen #(.WIDTH(58), .ORDER(58), .TAP(39), .INIT_SEED(58'h0), .DESCRAMBLE(0)) u_a (
    .clock(clock), .reset_n(reset_n), .data_in(a_din), .in_valid(a_iv), .enable(a_en),
    .bypass(a_byp), .reseed(a_rs), .data_out(a_dout), .out_valid(a_ov), .locked(a_lk));

  logic [15:0] s_din, s_dout, d_dout;
  logic        s_iv, s_ov, s_lk, d_ov, d_lk;

  scrambler_gen #(.WIDTH(16), .ORDER(58), .TAP(39), .INIT_SEED(58'h112abaa1231ba11), .DESCRAMBLE(0)) u_s (
    .clock(clock), .reset_n(reset_n), .data_in(s_din), .in_valid(s_iv), .enable(1'b1),
    .bypass(1'b0), .reseed(1'b0), .data_out(s_dout), .out_valid(s_ov), .locked(s_lk));

  scrambler_gen #(.WIDTH(16), .ORDER(58), .TAP(39), .INIT_SEED(58'h3), .DESCRAMBLE(1)) u_d (
    .clock(clock), .reset_n(reset_n), .data_in(s_dout), .in_valid(s_ov), .enable(1'b1),
    .bypass(1'b0), .reseed(1'b0), .data_out(d_dout), .out_valid(d_ov), .locked(d_lk));

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [57:0] m_hist, m_out;
  logic        m_valid;
  int          m_cnt;
  logic [57:0] q_a[$];
  logic [15:0] q16[$];
  int          rx, nd;
  logic        dv;
  logic [15:0] e16;
  logic [57:0] keep;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: history shifts one bit at a time, newest at [57].
  function automatic logic [115:0] scr58(input logic [57:0] h, input logic [57:0] d);
    logic [57:0] s;
    logic        b;
    s = '0;
    for (int k = 0; k < 58; k++) begin
      b    = d[k] ^ h[58-39] ^ h[0];
      s[k] = b;
      h    = {b, h[57:1]};
    end
    return {h, s};
  endfunction

  function automatic logic [57:0] rand58();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[57:0];
  endfunction

  task automatic step_a(input string tag, input logic [57:0] d, input logic v, input logic en,
                        input logic byp, input logic rs);
    logic [115:0] r;
    a_din = d; a_iv = v; a_en = en; a_byp = byp; a_rs = rs;
    r = scr58(m_hist, d);
    if (en && v) q_a.push_back(byp ? d : r[57:0]);
    if (en) begin
      m_valid = v;
      if (rs) begin
        m_hist = 58'h0;
        m_cnt  = 0;
      end else if (v && !byp) begin
        m_hist = r[115:58];
        if (m_cnt < 1) m_cnt++;
      end
    end
    @(posedge clock); #1;
    if (en && v) m_out = q_a.pop_front();
    check({tag, ".out"}, 64'(a_dout), 64'(m_out));
    check({tag, ".vld"}, 64'(a_ov), 64'(m_valid));
    check({tag, ".lk"},  64'(a_lk), 64'(m_cnt == 1));
  endtask

  initial begin
    reset_n = 1'b0;
    a_din = '0; a_iv = 1'b0; a_en = 1'b1; a_byp = 1'b0; a_rs = 1'b0;
    s_din = '0; s_iv = 1'b0;
    m_hist = 58'h0; m_out = '0; m_valid = 1'b0; m_cnt = 0;
    rx = 0; nd = 0;

    #12;
    check("rst.out", 64'(a_dout), 64'h0);
    check("rst.vld", 64'(a_ov), 64'h0);
    check("rst.lk",  64'(a_lk), 64'h0);
    check("rst.dlk", 64'(d_lk), 64'h0);

    #1 reset_n = 1'b1;
    step_a("first", 58'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("first.const", 64'(a_dout), 64'(58'h80_0000_0001));

    step_a("idle", 58'h3ff, 1'b0, 1'b1, 1'b0, 1'b0);
    step_a("rsd",  58'h0,   1'b0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      step_a("zero", 58'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("zero.const", 64'(a_dout), 64'h0);
      if (i >= 1) check("zero.lk", 64'(a_lk), 64'h1);
    end

    for (int i = 0; i < 6; i++) step_a("rnd", rand58(), 1'b1, 1'b1, 1'b0, 1'b0);

    // Stall with garbage inputs and an ignored reseed.
    for (int i = 0; i < 5; i++) step_a("stall", rand58(), 1'b1, 1'b0, 1'b0, i == 2);
    for (int i = 0; i < 4; i++) step_a("resume", rand58(), 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      keep = rand58();
      step_a("byp", keep, 1'b1, 1'b1, 1'b1, 1'b0);
      check("byp.const", 64'(a_dout), 64'(keep));
    end
    for (int i = 0; i < 4; i++) step_a("postbyp", rand58(), 1'b1, 1'b1, 1'b0, 1'b0);

    step_a("rsw", rand58(), 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step_a("postrsw", rand58(), 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset pulse with a word pending on the inputs.
    a_din = rand58(); a_iv = 1'b1; a_en = 1'b1; a_byp = 1'b0; a_rs = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst.out", 64'(a_dout), 64'h0);
    check("arst.vld", 64'(a_ov), 64'h0);
    check("arst.lk",  64'(a_lk), 64'h0);
    @(posedge clock); #1;
    check("arst2.out", 64'(a_dout), 64'h0);
    check("arst2.vld", 64'(a_ov), 64'h0);
    m_hist = 58'h0; m_cnt = 0; m_out = '0; m_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step_a("postrst", rand58(), 1'b1, 1'b1, 1'b0, 1'b0);

    // 16-bit scrambler -> descrambler loopback with mismatched seeds.
    for (int i = 0; i < 1002; i++) begin
      if (i < 1000) begin
        s_din = 16'($urandom());
        s_iv  = 1'b1;
        q16.push_back(s_din);
      end else begin
        s_iv = 1'b0;
      end
      dv = s_ov;
      @(posedge clock); #1;
      if (dv) rx++;
      check("lock16", 64'(d_lk), 64'(rx >= 4));
      if (i < 1000) check("slock16", 64'(s_lk), 64'((i + 1) >= 4));
      if (d_ov) begin
        e16 = q16.pop_front();
        nd++;
        if (nd >= 5) check("loop16", 64'(d_dout), 64'(e16));
      end
    end
    check("loop16.cnt", 64'(nd), 64'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
